// File: rtl/mux_rr_pkg.sv
// Shared types and the round-robin pick helper for the mux schedulers.
// The winner search is a rotate by ptr, then a priority encode, then an unrotate.
package mux_rr_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [SEL_W-1:0] idx;
  } pick_t;

  function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [SEL_W-1:0] ptr);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    pick_t             p;
    dbl     = {req, req};
    rot     = dbl[ptr +: NREQ];
    p.valid = |rot;
    p.idx   = ptr;
    // Walk downward so the lowest rotated position, i.e. closest to ptr, wins.
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        p.idx = ptr + SEL_W'(j);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Requester and downstream handshake bundle for mux_rr_scheduler.
// master is the scheduler side; slave is the requesters plus the downstream consumer.
interface mux_rr_scheduler_if #(
  parameter int WIDTH = 8
);
  import mux_rr_pkg::*;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] in_data;
  logic [NREQ-1:0]       ack;
  logic [SEL_W-1:0]      sel;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_src;
  logic                  out_ready;

  modport master (
    input  req, in_data, out_ready,
    output ack, sel, out_valid, out_data, out_src
  );

  modport slave (
    output req, in_data, out_ready,
    input  ack, sel, out_valid, out_data, out_src
  );

endinterface

// File: rtl/rr_pick4.sv
// Four-way round-robin winner select with a one-hot grant.
// The grant is gated by en so callers can suppress it when they cannot accept a word.
module rr_pick4
  import mux_rr_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic             valid,
  output logic [SEL_W-1:0] idx,
  output logic [NREQ-1:0]  ack
);

  pick_t pick_s;

  // Winner search and one-hot grant decode
  always_comb begin
    pick_s = rr_pick(req, ptr);
    valid  = pick_s.valid;
    idx    = pick_s.idx;
    if (en && pick_s.valid) begin
      ack = {{(NREQ-1){1'b0}}, 1'b1} << pick_s.idx;
    end else begin
      ack = {NREQ{1'b0}};
    end
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing one 4-way mux path, with a one-entry valid/ready output register.
// Define MUX_RR_HOLD_EN to let a winner keep priority for up to MAX_HOLD consecutive beats.
module mux_rr_scheduler
  import mux_rr_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 4
) (
  input logic                clk,
  input logic                rst_n,
  mux_rr_scheduler_if.master bus
);

  if (NREQ != 4) begin : g_nreq_chk
    $error("mux_rr_scheduler supports NREQ == 4 only");
  end
  if ((MAX_HOLD < 1) || (MAX_HOLD > 15)) begin : g_hold_chk
    $error("mux_rr_scheduler MAX_HOLD must be within 1..15");
  end

  state_t           state_r;
  state_t           state_nxt_s;
  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] ptr_nxt_s;
  logic [SEL_W-1:0] sel_r;
  logic [SEL_W-1:0] out_src_r;
  logic [SEL_W-1:0] win_idx_s;
  logic [WIDTH-1:0] out_data_r;
  logic [NREQ-1:0]  ack_s;
  logic             load_s;
  logic             win_valid_s;
  logic             capture_s;

  // The register can take a new word when empty or when its word leaves this cycle.
  assign load_s    = (state_r == IDLE) | bus.out_ready;
  assign capture_s = load_s & win_valid_s;

  rr_pick4 u_pick (
    .req   (bus.req),
    .ptr   (ptr_r),
    .en    (load_s & rst_n),
    .valid (win_valid_s),
    .idx   (win_idx_s),
    .ack   (ack_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: BUSY exactly while the output register holds a word
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (capture_s) state_nxt_s = BUSY;
        else           state_nxt_s = IDLE;
      end
      BUSY: begin
        if (load_s && !capture_s) state_nxt_s = IDLE;
        else                      state_nxt_s = BUSY;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output word, source index and mux select, loaded only on capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r <= {WIDTH{1'b0}};
      out_src_r  <= {SEL_W{1'b0}};
      sel_r      <= {SEL_W{1'b0}};
    end else if (capture_s) begin
      out_data_r <= bus.in_data[win_idx_s*WIDTH +: WIDTH];
      out_src_r  <= win_idx_s;
      sel_r      <= win_idx_s;
    end
  end

`ifdef MUX_RR_HOLD_EN
  logic [3:0] hold_cnt_r;
  logic [3:0] hold_cnt_nxt_s;
  logic [3:0] beats_s;

  // Parking ptr on the winner keeps it top priority; hold_cnt counts its consecutive beats.
  always_comb begin
    ptr_nxt_s      = ptr_r;
    hold_cnt_nxt_s = hold_cnt_r;
    beats_s        = (win_idx_s == ptr_r) ? (hold_cnt_r + 4'd1) : 4'd1;
    if (capture_s) begin
      if (beats_s < 4'(MAX_HOLD)) begin
        ptr_nxt_s      = win_idx_s;
        hold_cnt_nxt_s = beats_s;
      end else begin
        ptr_nxt_s      = win_idx_s + 2'd1;
        hold_cnt_nxt_s = 4'd0;
      end
    end else if (load_s && (hold_cnt_r != 4'd0) && !bus.req[ptr_r]) begin
      ptr_nxt_s      = ptr_r + 2'd1;
      hold_cnt_nxt_s = 4'd0;
    end else begin
      ptr_nxt_s      = ptr_r;
      hold_cnt_nxt_s = hold_cnt_r;
    end
  end

  // Hold counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_r <= 4'd0;
    end else begin
      hold_cnt_r <= hold_cnt_nxt_s;
    end
  end
`else
  // Pointer moves past every winner
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (capture_s) begin
      ptr_nxt_s = win_idx_s + 2'd1;
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end
`endif

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {SEL_W{1'b0}};
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  assign bus.ack       = ack_s;
  assign bus.sel       = sel_r;
  assign bus.out_valid = (state_r == BUSY);
  assign bus.out_data  = out_data_r;
  assign bus.out_src   = out_src_r;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Self-checking bench for mux_rr_scheduler: directed vector table, burst-hold sequence under
// MUX_RR_HOLD_EN, and randomized traffic compared against a behavioural queue-free reference model.
module tb_mux_rr_scheduler;

  localparam int W  = 8;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_rr_scheduler_if #(.WIDTH(W)) bus();

  mux_rr_scheduler #(.WIDTH(W), .NREQ(4), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: what the output register holds and who has priority next.
  bit       m_valid;
  bit [7:0] m_data;
  int       m_src;
  int       m_ptr;
  int       m_run;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        rdy;
    logic [3:0]  ack;
    logic        valid;
    logic [7:0]  odata;
    logic [1:0]  src;
  } vec_t;

  vec_t tab [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_src   = 0;
    m_ptr   = 0;
    m_run   = 0;
  endtask

  // Winner = first requester at or after ptr, going round the ring.
  task automatic model_eval(input logic [3:0] r, input logic rdy, output logic [3:0] a, output int w);
    w = -1;
    if (!m_valid || rdy) begin
      for (int o = 0; o < 4; o++) begin
        int i;
        i = (m_ptr + o) % 4;
        if (w < 0 && r[i]) w = i;
      end
    end
    a = (w >= 0) ? (4'b0001 << w) : 4'b0000;
  endtask

  task automatic model_commit(input logic [3:0] r, input logic [31:0] d, input logic rdy, input int w);
    if (!m_valid || rdy) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = d[w*8 +: 8];
        m_src   = w;
`ifdef MUX_RR_HOLD_EN
        m_run = (w == m_ptr) ? m_run + 1 : 1;
        if (m_run < MH) m_ptr = w;
        else begin
          m_ptr = (w + 1) % 4;
          m_run = 0;
        end
`else
        m_ptr = (w + 1) % 4;
`endif
      end else begin
        m_valid = 1'b0;
`ifdef MUX_RR_HOLD_EN
        if (m_run != 0 && !r[m_ptr]) begin
          m_run = 0;
          m_ptr = (m_ptr + 1) % 4;
        end
`endif
      end
    end
  endtask

  task automatic cycle_model(input logic [3:0] r, input logic [31:0] d, input logic rdy);
    logic [3:0] a;
    int         w;
    @(negedge clk);
    bus.req = r; bus.in_data = d; bus.out_ready = rdy;
    #1;
    model_eval(r, rdy, a, w);
    check("rnd ack", bus.ack, a);
    check("rnd out_valid", bus.out_valid, m_valid);
    check("rnd out_data", bus.out_data, m_data);
    check("rnd out_src", bus.out_src, m_src);
    check("rnd sel", bus.sel, m_src);
    model_commit(r, d, rdy, w);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = 4'b1111; bus.in_data = 32'h0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset ack", bus.ack, 4'b0000);
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset sel", bus.sel, 2'd0);
    check("reset out_data", bus.out_data, 8'h00);
    model_reset();
    bus.req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // req, data, ready, expected ack, then the registered outputs visible that cycle
    tab[0]  = '{4'b1111, 32'h44332211, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0};
    tab[1]  = '{4'b1111, 32'h44332211, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd0};
    tab[2]  = '{4'b1111, 32'h44332211, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd1};
    tab[3]  = '{4'b1111, 32'h44332211, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd2};
    tab[4]  = '{4'b1111, 32'h44332211, 1'b1, 4'b0001, 1'b1, 8'h44, 2'd3};
    tab[5]  = '{4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd0};
    tab[6]  = '{4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    tab[7]  = '{4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    tab[8]  = '{4'b0010, 32'h00003C00, 1'b1, 4'b0010, 1'b1, 8'hA5, 2'd2};
    for (int i = 9; i < 14; i++) tab[i] = '{4'b1011, 32'h77003C66, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd1};
    tab[14] = '{4'b1011, 32'h77003C66, 1'b1, 4'b1000, 1'b1, 8'h3C, 2'd1};
    tab[15] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 8'h77, 2'd3};
    tab[16] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h77, 2'd3};
    tab[17] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 8'h77, 2'd3};
    tab[18] = '{4'b0100, 32'h00550000, 1'b1, 4'b0100, 1'b0, 8'h77, 2'd3};
    tab[19] = '{4'b1001, 32'h99000088, 1'b1, 4'b1000, 1'b1, 8'h55, 2'd2};
    tab[20] = '{4'b1001, 32'h99000088, 1'b1, 4'b0001, 1'b1, 8'h99, 2'd3};
    tab[21] = '{4'b1001, 32'h99000088, 1'b1, 4'b1000, 1'b1, 8'h88, 2'd0};
    tab[22] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h99, 2'd3};
    tab[23] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h99, 2'd3};

    do_reset();

`ifndef MUX_RR_HOLD_EN
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bus.req = tab[i].req; bus.in_data = tab[i].data; bus.out_ready = tab[i].rdy;
      #1;
      check($sformatf("tab%0d ack", i), bus.ack, tab[i].ack);
      check($sformatf("tab%0d out_valid", i), bus.out_valid, tab[i].valid);
      check($sformatf("tab%0d out_data", i), bus.out_data, tab[i].odata);
      check($sformatf("tab%0d out_src", i), bus.out_src, tab[i].src);
      check($sformatf("tab%0d sel", i), bus.sel, tab[i].src);
    end
`else
    begin
      logic [3:0] hold_exp [9];
      hold_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        bus.req = 4'b0011; bus.in_data = 32'h0000BBAA; bus.out_ready = 1'b1;
        #1;
        check($sformatf("hold%0d ack", i), bus.ack, hold_exp[i]);
      end
    end
`endif

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      cycle_model(r, $urandom, ($urandom_range(0, 3) != 0));
    end

    // Reset while a word is held: the word is dropped and no grant is issued
    cycle_model(4'b0010, 32'h0000C300, 1'b0);
    cycle_model(4'b0010, 32'h0000C300, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = 4'b1111;
    #1;
    check("midreset ack", bus.ack, 4'b0000);
    check("midreset out_valid", bus.out_valid, 1'b0);
    check("midreset out_data", bus.out_data, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
